// File: rtl/dcache_mem_stage.sv
// -----------------------------------------------------------------------------
// dcache_mem_stage
//
// Memory-stage data cache controller. Direct-mapped, one 32-bit word per line,
// write-through, no-write-allocate. Talks to main memory over a single
// req/ack handshake with variable latency. Cache_Stall freezes every pipeline
// register (including EX/MEM), so ALUResultM / WriteDataM are held while the
// controller is busy.
//
// Ports:
//   CLK          clock, all state changes on the rising edge
//   RESETn       synchronous active-low reset
//   MemtoRegM    load in M stage
//   MemWriteM    store in M stage (wins when both are set)
//   ALUResultM   byte address, bits [1:0] ignored
//   WriteDataM   store data
//   ReadDataM    load data, valid when MemtoRegM=1 and Cache_Stall=0
//   Cache_Stall  combinational pipeline freeze
//   MemReq       registered main-memory request
//   MemWE        registered write (1) / read (0) qualifier
//   MemAddr      registered word-aligned address
//   MemWData     registered write data
//   MemRData     main-memory read data, valid with MemAck
//   MemAck       one-cycle completion pulse, ignored unless MemReq=1
// -----------------------------------------------------------------------------
module dcache_mem_stage #(
    parameter  int INDEX_BITS = 4,
    localparam int TAG_BITS   = 30 - INDEX_BITS,
    localparam int LINES      = 1 << INDEX_BITS
) (
    input  logic        CLK,
    input  logic        RESETn,
    input  logic        MemtoRegM,
    input  logic        MemWriteM,
    input  logic [31:0] ALUResultM,
    input  logic [31:0] WriteDataM,
    output logic [31:0] ReadDataM,
    output logic        Cache_Stall,
    output logic        MemReq,
    output logic        MemWE,
    output logic [31:0] MemAddr,
    output logic [31:0] MemWData,
    input  logic [31:0] MemRData,
    input  logic        MemAck
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RFILL = 2'd1,
        WRITE = 2'd2,
        WDONE = 2'd3
    } state_t;

    state_t                  state_q;
    logic                    mem_req_q;
    logic                    mem_we_q;
    logic [31:0]             mem_addr_q;
    logic [31:0]             mem_wdata_q;
    logic [LINES-1:0]        valid_q;

    // Tag/data arrays carry no reset; only the valid bits are cleared.
    logic [TAG_BITS-1:0]     tag_mem  [LINES];
    logic [31:0]             data_mem [LINES];

    logic [INDEX_BITS-1:0]   idx;
    logic [TAG_BITS-1:0]     tag;
    logic [INDEX_BITS-1:0]   fill_idx;
    logic [TAG_BITS-1:0]     fill_tag;
    logic                    hit;
    logic [31:0]             word_addr;
    logic                    unused_addr_bits;

    assign idx       = ALUResultM[INDEX_BITS+1:2];
    assign tag       = ALUResultM[31:INDEX_BITS+2];
    assign hit       = valid_q[idx] && (tag_mem[idx] == tag);
    assign word_addr = {ALUResultM[31:2], 2'b00};

    // Fills are steered by the latched request address, not the live inputs.
    assign fill_idx  = mem_addr_q[INDEX_BITS+1:2];
    assign fill_tag  = mem_addr_q[31:INDEX_BITS+2];

    assign unused_addr_bits = ^ALUResultM[1:0];

    assign MemReq   = mem_req_q;
    assign MemWE    = mem_we_q;
    assign MemAddr  = mem_addr_q;
    assign MemWData = mem_wdata_q;

    // Stall: busy states always stall; IDLE stalls on any store or a load miss.
    // WDONE releases the pipeline for exactly one cycle so the store retires once.
    always_comb begin
        Cache_Stall = 1'b0;
        case (state_q)
            IDLE:    Cache_Stall = MemWriteM || (MemtoRegM && !hit);
            RFILL:   Cache_Stall = 1'b1;
            WRITE:   Cache_Stall = 1'b1;
            WDONE:   Cache_Stall = 1'b0;
            default: Cache_Stall = 1'b0;
        endcase
    end

    always_comb begin
        ReadDataM = 32'd0;
        if (state_q == IDLE && MemtoRegM && !MemWriteM && hit) begin
            ReadDataM = data_mem[idx];
        end
    end

    // Controller FSM with registered memory-interface outputs.
    always_ff @(posedge CLK) begin
        if (!RESETn) begin
            state_q     <= IDLE;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= 32'd0;
            mem_wdata_q <= 32'd0;
            valid_q     <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (MemWriteM) begin
                        state_q     <= WRITE;
                        mem_req_q   <= 1'b1;
                        mem_we_q    <= 1'b1;
                        mem_addr_q  <= word_addr;
                        mem_wdata_q <= WriteDataM;
                    end else if (MemtoRegM && !hit) begin
                        state_q    <= RFILL;
                        mem_req_q  <= 1'b1;
                        mem_we_q   <= 1'b0;
                        mem_addr_q <= word_addr;
                    end
                end
                RFILL: begin
                    if (MemAck) begin
                        valid_q[fill_idx] <= 1'b1;
                        mem_req_q         <= 1'b0;
                        state_q           <= IDLE;
                    end
                end
                WRITE: begin
                    if (MemAck) begin
                        mem_req_q <= 1'b0;
                        mem_we_q  <= 1'b0;
                        state_q   <= WDONE;
                    end
                end
                WDONE: begin
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    // Array updates: store hits write through into the line; refills install
    // data and tag. A store miss leaves the arrays untouched (no allocate).
    always_ff @(posedge CLK) begin
        if (RESETn) begin
            if (state_q == IDLE && MemWriteM && hit) begin
                data_mem[idx] <= WriteDataM;
            end else if (state_q == RFILL && MemAck) begin
                data_mem[fill_idx] <= MemRData;
                tag_mem[fill_idx]  <= fill_tag;
            end
        end
    end

endmodule

// File: tb/tb_dcache_mem_stage.sv
module tb_dcache_mem_stage;

    logic        CLK;
    logic        RESETn;
    logic        MemtoRegM;
    logic        MemWriteM;
    logic [31:0] ALUResultM;
    logic [31:0] WriteDataM;
    logic [31:0] ReadDataM;
    logic        Cache_Stall;
    logic        MemReq;
    logic        MemWE;
    logic [31:0] MemAddr;
    logic [31:0] MemWData;
    logic [31:0] MemRData;
    logic        MemAck;

    int n_cmp = 0;
    int n_err = 0;

    dcache_mem_stage #(.INDEX_BITS(4)) dut (
        .CLK         (CLK),
        .RESETn      (RESETn),
        .MemtoRegM   (MemtoRegM),
        .MemWriteM   (MemWriteM),
        .ALUResultM  (ALUResultM),
        .WriteDataM  (WriteDataM),
        .ReadDataM   (ReadDataM),
        .Cache_Stall (Cache_Stall),
        .MemReq      (MemReq),
        .MemWE       (MemWE),
        .MemAddr     (MemAddr),
        .MemWData    (MemWData),
        .MemRData    (MemRData),
        .MemAck      (MemAck)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed=%08h expected=%08h", tag, obs, exp);
        end
    endtask

    // Load already presented in IDLE and known to miss: walk it through the
    // refill with MemAck in the first request cycle, then check the hit.
    task automatic load_fill(input string tag, input logic [31:0] addr, input logic [31:0] rdata);
        tick();
        chk({tag, "_req"},   {31'd0, MemReq}, 32'd1);
        chk({tag, "_we"},    {31'd0, MemWE}, 32'd0);
        chk({tag, "_addr"},  MemAddr, addr);
        chk({tag, "_stall"}, {31'd0, Cache_Stall}, 32'd1);
        MemAck   = 1'b1;
        MemRData = rdata;
        tick();
        MemAck   = 1'b0;
        MemRData = 32'd0;
        settle();
        chk({tag, "_done_stall"}, {31'd0, Cache_Stall}, 32'd0);
        chk({tag, "_done_data"},  ReadDataM, rdata);
        chk({tag, "_done_req"},   {31'd0, MemReq}, 32'd0);
        $display("txn load-miss addr=%08h data=%08h", addr, ReadDataM);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        RESETn     = 1'b0;
        MemtoRegM  = 1'b0;
        MemWriteM  = 1'b0;
        ALUResultM = 32'd0;
        WriteDataM = 32'd0;
        MemRData   = 32'd0;
        MemAck     = 1'b0;
        tick();
        tick();
        chk("rst_req",   {31'd0, MemReq}, 32'd0);
        chk("rst_we",    {31'd0, MemWE}, 32'd0);
        chk("rst_addr",  MemAddr, 32'd0);
        chk("rst_wdata", MemWData, 32'd0);
        RESETn = 1'b1;
        settle();
        chk("idle_stall", {31'd0, Cache_Stall}, 32'd0);
        chk("idle_rdata", ReadDataM, 32'd0);
        $display("txn reset");

        // Cold load of 0x40: stall 2 cycles, data on the 3rd.
        MemtoRegM  = 1'b1;
        ALUResultM = 32'h0000_0040;
        settle();
        chk("ld40_c1_stall", {31'd0, Cache_Stall}, 32'd1);
        chk("ld40_c1_req",   {31'd0, MemReq}, 32'd0);
        load_fill("ld40_cold", 32'h0000_0040, 32'hDEAD_BEEF);

        // Same load again: hit with no stall and no request.
        tick();
        chk("ld40_hit_stall", {31'd0, Cache_Stall}, 32'd0);
        chk("ld40_hit_data",  ReadDataM, 32'hDEAD_BEEF);
        chk("ld40_hit_req",   {31'd0, MemReq}, 32'd0);
        $display("txn load-hit addr=00000040 data=%08h", ReadDataM);

        // Store hit to 0x40, MemAck on the 3rd request cycle: 4 stall cycles.
        MemtoRegM  = 1'b0;
        MemWriteM  = 1'b1;
        WriteDataM = 32'h1234_5678;
        settle();
        chk("st40_c1_stall", {31'd0, Cache_Stall}, 32'd1);
        tick();
        chk("st40_c2_stall", {31'd0, Cache_Stall}, 32'd1);
        chk("st40_c2_req",   {31'd0, MemReq}, 32'd1);
        chk("st40_c2_we",    {31'd0, MemWE}, 32'd1);
        chk("st40_c2_addr",  MemAddr, 32'h0000_0040);
        chk("st40_c2_wdata", MemWData, 32'h1234_5678);
        tick();
        chk("st40_c3_stall", {31'd0, Cache_Stall}, 32'd1);
        chk("st40_c3_req",   {31'd0, MemReq}, 32'd1);
        tick();
        MemAck = 1'b1;
        settle();
        chk("st40_c4_stall", {31'd0, Cache_Stall}, 32'd1);
        tick();
        MemAck = 1'b0;
        settle();
        chk("st40_wdone_stall", {31'd0, Cache_Stall}, 32'd0);
        chk("st40_wdone_req",   {31'd0, MemReq}, 32'd0);
        chk("st40_wdone_we",    {31'd0, MemWE}, 32'd0);
        $display("txn store-hit addr=00000040 data=12345678");
        // Pipeline advances out of WDONE into a load of 0x40.
        MemWriteM = 1'b0;
        MemtoRegM = 1'b1;
        tick();
        chk("ld40_after_st_stall", {31'd0, Cache_Stall}, 32'd0);
        chk("ld40_after_st_data",  ReadDataM, 32'h1234_5678);
        $display("txn load-hit addr=00000040 data=%08h", ReadDataM);

        // Store miss to 0x80: write-through only, MemAck in first request cycle.
        MemtoRegM  = 1'b0;
        MemWriteM  = 1'b1;
        ALUResultM = 32'h0000_0080;
        WriteDataM = 32'hCAFE_F00D;
        settle();
        chk("st80_c1_stall", {31'd0, Cache_Stall}, 32'd1);
        tick();
        chk("st80_req",   {31'd0, MemReq}, 32'd1);
        chk("st80_we",    {31'd0, MemWE}, 32'd1);
        chk("st80_addr",  MemAddr, 32'h0000_0080);
        chk("st80_wdata", MemWData, 32'hCAFE_F00D);
        MemAck = 1'b1;
        tick();
        MemAck = 1'b0;
        settle();
        chk("st80_wdone_stall", {31'd0, Cache_Stall}, 32'd0);
        $display("txn store-miss addr=00000080 data=cafef00d");
        MemWriteM  = 1'b0;
        MemtoRegM  = 1'b1;
        ALUResultM = 32'h0000_0040;
        tick();
        // Same index, different tag: the miss store must not have touched the line.
        chk("ld40_post_st80_stall", {31'd0, Cache_Stall}, 32'd0);
        chk("ld40_post_st80_data",  ReadDataM, 32'h1234_5678);
        ALUResultM = 32'h0000_0080;
        settle();
        chk("ld80_noalloc_stall", {31'd0, Cache_Stall}, 32'd1);
        load_fill("ld80", 32'h0000_0080, 32'hCAFE_F00D);

        // Conflict on index 0: 0x40 and 0x440 evict each other.
        ALUResultM = 32'h0000_0040;
        settle();
        chk("ld40_evicted_stall", {31'd0, Cache_Stall}, 32'd1);
        load_fill("ld40_refill", 32'h0000_0040, 32'h1234_5678);
        ALUResultM = 32'h0000_0440;
        settle();
        chk("ld440_miss_stall", {31'd0, Cache_Stall}, 32'd1);
        load_fill("ld440", 32'h0000_0440, 32'h55AA_55AA);
        ALUResultM = 32'h0000_0040;
        settle();
        chk("ld40_conflict_stall", {31'd0, Cache_Stall}, 32'd1);
        load_fill("ld40_again", 32'h0000_0040, 32'h1234_5678);

        // Reset in RFILL before MemAck; a late MemAck must be ignored.
        ALUResultM = 32'h0000_0440;
        settle();
        chk("ld440b_stall", {31'd0, Cache_Stall}, 32'd1);
        tick();
        chk("ld440b_rfill_req", {31'd0, MemReq}, 32'd1);
        RESETn = 1'b0;
        tick();
        RESETn    = 1'b1;
        MemtoRegM = 1'b0;
        settle();
        chk("abort_req",   {31'd0, MemReq}, 32'd0);
        chk("abort_stall", {31'd0, Cache_Stall}, 32'd0);
        MemAck   = 1'b1;
        MemRData = 32'hBAD0_BAD0;
        tick();
        MemAck   = 1'b0;
        MemRData = 32'd0;
        settle();
        chk("late_ack_req",   {31'd0, MemReq}, 32'd0);
        chk("late_ack_stall", {31'd0, Cache_Stall}, 32'd0);
        $display("txn reset-abort");
        MemtoRegM  = 1'b1;
        ALUResultM = 32'h0000_0040;
        settle();
        chk("ld40_post_rst_stall", {31'd0, Cache_Stall}, 32'd1);
        tick();
        chk("ld40_post_rst_req",  {31'd0, MemReq}, 32'd1);
        chk("ld40_post_rst_addr", MemAddr, 32'h0000_0040);
        $display("txn load-miss-after-reset addr=00000040");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/dcache_mem_stage.md
Name: dcache_mem_stage

Overview:
Memory-stage data cache controller. It consumes the EX/MEM pipeline register outputs and drives Cache_Stall back to every pipeline register that honours it, including the EX/MEM register. It is direct-mapped, one 32-bit word per line, write-through and no-write-allocate. It talks to main memory over a single req/ack handshake with variable latency.

Parameters:
INDEX_BITS, 4, line index width; the cache has 2^INDEX_BITS lines.
TAG_BITS, 30-INDEX_BITS (derived, not overridable), tag width.

Ports:
CLK  input  1  clock; all state updates on the rising edge.
RESETn  input  1  reset, synchronous, active-low.
MemtoRegM  input  1  load in M stage.
MemWriteM  input  1  store in M stage.
ALUResultM  input  32  byte address; bits [1:0] ignored.
WriteDataM  input  32  store data.
ReadDataM  output  32  load data; valid when MemtoRegM=1 and Cache_Stall=0.
Cache_Stall  output  1  combinational; freezes the pipeline registers.
MemReq  output  1  main-memory request (registered).
MemWE  output  1  1 = write request, 0 = read request (registered).
MemAddr  output  32  word-aligned address, {ALUResultM[31:2],2'b00} (registered).
MemWData  output  32  write data (registered).
MemRData  input  32  read data; valid when MemAck=1.
MemAck  input  1  one-cycle completion pulse; only meaningful while MemReq=1.

Behaviour:
- Address split:
  - idx = ALUResultM[INDEX_BITS+1:2]
  - tag = ALUResultM[31:INDEX_BITS+2]
  - hit = valid[idx] && tagarr[idx]==tag
- Reset (RESETn=0 at an edge):
  - all valid bits cleared; state=IDLE.
  - MemReq=0, MemWE=0, MemAddr=0, MemWData=0.
  - Data and tag arrays are not cleared.
- Reset mid-transaction: the transaction is aborted, MemReq drops at that edge, and any later MemAck is ignored.
- FSM states: IDLE, RFILL, WRITE, WDONE.
- IDLE:
  - Load hit: ReadDataM=data[idx] combinationally, Cache_Stall=0, zero extra latency.
  - Load miss: Cache_Stall=1. Next edge: state=RFILL, MemReq=1, MemWE=0, MemAddr latched.
  - Store (hit or miss): Cache_Stall=1.
    - On a hit, data[idx] is written with WriteDataM at this edge.
    - On a miss, no allocate.
    - Next edge: state=WRITE, MemReq=1, MemWE=1, MemAddr and MemWData latched.
  - MemtoRegM and MemWriteM both 1: treated as a store.
  - Neither asserted: Cache_Stall=0; ReadDataM=0.
- RFILL:
  - Cache_Stall=1.
  - On MemAck: data[idx]=MemRData, tagarr[idx]=tag, valid[idx]=1, MemReq=0, state=IDLE.
  - The held instruction then hits in IDLE on the following cycle.
- WRITE:
  - Cache_Stall=1.
  - On MemAck: MemReq=0, MemWE=0, state=WDONE.
- WDONE:
  - Cache_Stall=0, so the store retires exactly once.
  - Unconditionally return to IDLE; no new request is issued from WDONE.
- Request stability: while MemReq=1, MemWE, MemAddr and MemWData are stable. MemAck with MemReq=0 has no effect.
- Latency with MemAck in the first cycle MemReq=1:
  - Load miss: 2 stall cycles, result on the 3rd cycle.
  - Store: 2 stall cycles; WDONE is the retire cycle.
- Latency scaling: each additional cycle before MemAck adds one stall cycle.
- Stall behaviour: ALUResultM and WriteDataM are assumed held by the stalled EX/MEM register. The block also uses its own latched MemAddr and MemWData, so fill and write use the latched copy.

Test Plan:
- Reset then load 0x0000_0040 with memory returning 0xDEAD_BEEF, MemAck 1 cycle after MemReq rises:
  - Cache_Stall high for 2 cycles; MemReq=1, MemWE=0, MemAddr=0x40.
  - 3rd cycle: ReadDataM=0xDEAD_BEEF, Cache_Stall=0.
- Repeat load 0x40 → hit; Cache_Stall=0 in the same cycle; ReadDataM=0xDEAD_BEEF; MemReq stays 0.
- Store 0x1234_5678 to 0x40 (hit), MemAck after 3 cycles:
  - MemWE=1, MemWData=0x1234_5678; Cache_Stall high for 4 cycles, low in WDONE.
  - A subsequent load of 0x40 hits with 0x1234_5678.
- Store to 0x0000_0080 (miss) → write-through issued; a following load of 0x80 misses (no allocate).
- Conflict: load 0x40, then load 0x0000_0440 (same idx 0x0, different tag):
  - second load misses, refills, and evicts.
  - load 0x40 misses again.
- Assert RESETn=0 during RFILL with MemAck not yet returned:
  - next edge MemReq=0, state IDLE.
  - a late MemAck is ignored; a load of 0x40 afterwards misses.
